// File: rtl/demux32bit1to8_buf.sv
// demux32bit1to8_buf
// Registered 1-to-8 word demultiplexer. Each of the eight channels is a
// one-entry holding register with its own valid/ready handshake toward its
// consumer. A single producer port steers each accepted word to the channel
// named by in_sel.
//
// Optional feature: define DEMUX32_STATS_EN to add the 16-bit saturating
// accept_cnt output, which counts accepted pushes.
//
// Handshake rules (both sides): a transfer happens at a rising Clk edge when
// valid and ready are both 1 on that side. A producer holding valid while
// ready is low must keep its payload stable. in_ready may be sampled without
// in_valid being asserted. out_valid[k] does not depend on out_ready[k].

module demux32bit1to8_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_sel,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [7:0]              out_valid,
    input  logic [7:0]              out_ready,
    output logic [8*DATA_WIDTH-1:0] out_data,
    output logic                    busy
`ifdef DEMUX32_STATS_EN
    ,
    output logic [15:0]             accept_cnt
`endif
);

    // Per-channel occupancy: bit k set means channel k is FULL. This vector
    // is the complete control state of the block and is exported directly
    // as out_valid.
    logic [7:0]            valid_q;
    logic [7:0]            valid_d;
    logic [DATA_WIDTH-1:0] data_q [8];
    logic [DATA_WIDTH-1:0] data_d [8];

    logic                  push;
    logic [7:0]            push_vec;
    logic [7:0]            pop_vec;

    // A channel can take a word if it is empty or is being drained this
    // same edge. Only in_sel and out_ready reach in_ready combinationally.
    assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    assign push     = in_valid & in_ready;

    // Decode the push into a one-hot channel mask and collect the pops.
    always_comb begin
        push_vec = 8'h00;
        if (push) begin
            push_vec = 8'h01 << in_sel;
        end
        pop_vec = valid_q & out_ready;
    end

    // Next occupancy and contents: a push on the same edge as a pop wins, so
    // the channel stays FULL with the new word and no bubble appears.
    always_comb begin
        valid_d = (valid_q & ~pop_vec) | push_vec;
        for (int k = 0; k < 8; k++) begin
            data_d[k] = push_vec[k] ? in_data : data_q[k];
        end
    end

    // Channel state registers; reset discards any held words.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Flatten the per-channel registers onto the output bus.
    for (genvar g = 0; g < 8; g++) begin : g_out
        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

    assign out_valid = valid_q;
    assign busy      = |valid_q;

`ifdef DEMUX32_STATS_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Count accepted pushes, sticking at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (push && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register; a push in the reset cycle is not counted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign accept_cnt = cnt_q;
`endif

endmodule

// File: doc/demux32bit1to8_buf.md
# demux32bit1to8_buf

Registered 1-to-8 demultiplexer that routes a 32-bit word from one producer to one of eight consumer channels selected by a 3-bit index.
- Each channel has a one-entry holding register and a valid/ready handshake.
- Serves as the distribution end of the 8-input word-selection path: results produced on one bus are steered to one of eight sinks, such as write-back targets or per-unit queues.
- One word can be accepted per cycle, including while the target channel is draining.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each data word.

Ports (one clock; reset is synchronous and active-high):
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word addressed by in_sel this cycle.
- in_sel  input  3  destination channel index, 0..7.
- in_data  input  DATA_WIDTH  word to route.
- out_valid  output  8  bit k = channel k holds a word.
- out_ready  input  8  bit k = consumer k takes the word this cycle.
- out_data  output  8*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- busy  output  1  OR of out_valid.
- accept_cnt  output  16  saturating count of accepted words; present only with the stats macro.

## Operation
- Per channel k, state is EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - Combinational from in_sel and out_ready.
  - Defined regardless of in_valid.
- Push: in_valid & in_ready at a rising edge.
  - in_data is written to channel in_sel and out_valid[in_sel] is set.
- Pop: out_valid[k] & out_ready[k] at a rising edge.
  - out_valid[k] is cleared unless the same edge pushes to k.
- Simultaneous push and pop on the same channel:
  - The new word replaces the old one.
  - out_valid stays 1.
  - No bubble.
- Pushes and pops on different channels are independent; all eight channels may pop in the same cycle.
- While a channel is FULL and not popped, out_data[k] is held stable.
- A channel that is EMPTY holds its last word on out_data. Consumers must ignore it.
- When in_valid=0, in_sel and in_data are don't-care and no state changes due to input.
- in_ready for a FULL, unpopped channel is 0. The producer must hold in_valid, in_sel and in_data until accepted.
  - Changing in_sel while stalled is permitted; acceptance is re-evaluated against the new channel.
- busy = |out_valid.

## Timing
- Reset (synchronous, sampled at Clk edge):
  - out_valid=8'h00.
  - All out_data=0.
  - busy=0.
  - accept_cnt=0.
  - in_ready=1 after reset, since all channels are EMPTY.
- Reset has priority over a concurrent push or pop.
  - Words in flight at reset are discarded.
  - A push asserted in the reset cycle is not accepted and not counted.
- Latency: a word pushed at edge N appears with out_valid set after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle sustained to a single channel if its consumer holds out_ready=1. Otherwise 1 word/cycle while the targeted channels are EMPTY.
- No combinational path from in_valid or in_data to any output. The only combinational paths are in_sel and out_ready to in_ready.

## Configuration
- Macro DEMUX32_STATS_EN.
- Defined:
  - The accept_cnt port exists.
  - It increments by 1 on every accepted push.
  - It saturates at 16'hFFFF and never wraps.
  - It clears on Reset.
- Undefined:
  - The accept_cnt port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then push 0xDEADBEEF to sel=3 with out_ready=0 → next cycle out_valid=8'h08, out_data[3]=0xDEADBEEF, busy=1, others 0.
- Channel 3 FULL, out_ready=0, push sel=3 value 0x1 → in_ready=0; word held for 4 cycles; raise out_ready[3] → 0x1 accepted that edge, out_data[3]=0x1 next cycle, valid stays 1.
- out_ready=8'hFF, push 0..7 to sel 0..7 on consecutive cycles → each word visible one cycle after push, in_ready constant 1, no drops.
- Channels 2 and 5 FULL, pop both and push to sel=6 in the same cycle → out_valid becomes 8'h40.
- Fill channel 1, assert Reset together with a push to sel=4 → out_valid=0, out_data all 0, accept_cnt=0.
- With DEMUX32_STATS_EN and out_ready=8'hFF, perform 70000 pushes → accept_cnt=16'hFFFF and stays there.
